rs_wakeup_station: RTL and testbench

Parametrised successor to the single-cycle reservation station. It holds up to RS_DEPTH dispatched ops and captures operands from N_CDB result-broadcast channels, including a same-cycle bypass at dispatch. Each cycle it issues the lowest-index ready entry to the ALU through a registered valid/op bundle. It sits between the dispatcher and the ALU, and it supports flush on branch mispredict and an occupancy count.

---
 rtl/rs_wakeup_station_pkg.sv | 22 ++
 rtl/rs_wakeup_station_prio_enc.sv | 25 ++
 rtl/rs_wakeup_station.sv | 202 ++++++++++++++++++++
 tb/tb_rs_wakeup_station.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_wakeup_station_pkg.sv
// Shared widths, opcode-type encodings and constants for the wakeup reservation station.
package rs_wakeup_station_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 4;
    localparam int OP_W_DEF   = 6;

    localparam logic [OP_W_DEF-1:0] OP_ALU    = 6'h00;
    localparam logic [OP_W_DEF-1:0] OP_SHIFT  = 6'h01;
    localparam logic [OP_W_DEF-1:0] OP_BRANCH = 6'h02;
    localparam logic [OP_W_DEF-1:0] OP_MULT   = 6'h03;

    localparam logic FALSE = 1'b0;
    localparam logic TRUE  = 1'b1;
    localparam logic [DATA_W_DEF-1:0] ZERO = '0;

    // Index width for a one-hot/priority search over n requesters, at least one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rs_wakeup_station_prio_enc.sv
// Lowest-set-bit priority encoder: found flag plus index of the lowest asserted request.
module rs_prio_enc
    import rs_wakeup_station_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        found = FALSE;
        idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = TRUE;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_wakeup_station.sv
// Reservation station with N_CDB-channel operand wakeup, dispatch bypass and lowest-index issue.
module rs_wakeup_station
    import rs_wakeup_station_pkg::*;
#(
    parameter int RS_DEPTH = 16,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int OP_W     = OP_W_DEF,
    parameter int N_CDB    = 2,
    localparam int IDX_W   = idx_w(RS_DEPTH),
    localparam int CNT_W   = $clog2(RS_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    clr,
    output logic                    full,
    output logic [CNT_W-1:0]        count,
    input  logic                    disp_valid,
    input  logic [OP_W-1:0]         disp_op,
    input  logic [DATA_W-1:0]       disp_pc,
    input  logic                    disp_qj_v,
    input  logic                    disp_qk_v,
    input  logic [TAG_W-1:0]        disp_qj,
    input  logic [TAG_W-1:0]        disp_qk,
    input  logic [DATA_W-1:0]       disp_vj,
    input  logic [DATA_W-1:0]       disp_vk,
    input  logic [DATA_W-1:0]       disp_imm,
    input  logic [TAG_W-1:0]        disp_dest,
    input  logic [N_CDB-1:0]        cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [N_CDB*DATA_W-1:0] cdb_value,
    output logic                    alu_valid,
    output logic [OP_W-1:0]         alu_op,
    output logic [DATA_W-1:0]       alu_pc,
    output logic [DATA_W-1:0]       alu_vj,
    output logic [DATA_W-1:0]       alu_vk,
    output logic [DATA_W-1:0]       alu_imm,
    output logic [TAG_W-1:0]        alu_dest
);

    logic [RS_DEPTH-1:0] busy;
    logic [RS_DEPTH-1:0] qj_v;
    logic [RS_DEPTH-1:0] qk_v;
    logic [TAG_W-1:0]    qj   [RS_DEPTH];
    logic [TAG_W-1:0]    qk   [RS_DEPTH];
    logic [DATA_W-1:0]   vj   [RS_DEPTH];
    logic [DATA_W-1:0]   vk   [RS_DEPTH];
    logic [DATA_W-1:0]   pc   [RS_DEPTH];
    logic [DATA_W-1:0]   imm  [RS_DEPTH];
    logic [OP_W-1:0]     op   [RS_DEPTH];
    logic [TAG_W-1:0]    dest [RS_DEPTH];

    logic [RS_DEPTH-1:0] ready_p0;
    logic                free_vld_p0;
    logic [IDX_W-1:0]    free_idx_p0;
    logic                issue_vld_p0;
    logic [IDX_W-1:0]    issue_idx_p0;
    logic                disp_fire_p0;
    logic [CNT_W-1:0]    count_nxt_p0;

    logic                byp_j_p0, byp_k_p0;
    logic [DATA_W-1:0]   byp_vj_p0, byp_vk_p0;

    logic [RS_DEPTH-1:0] wake_j_p0, wake_k_p0;
    logic [DATA_W-1:0]   wval_j_p0 [RS_DEPTH];
    logic [DATA_W-1:0]   wval_k_p0 [RS_DEPTH];

    // ---- stage p0: slot search, ready select and operand match on registered state ----
    assign ready_p0 = busy & ~qj_v & ~qk_v;

    rs_prio_enc #(.WIDTH(RS_DEPTH), .IDX_W(IDX_W)) u_free_enc (
        .req   (~busy),
        .found (free_vld_p0),
        .idx   (free_idx_p0)
    );

    rs_prio_enc #(.WIDTH(RS_DEPTH), .IDX_W(IDX_W)) u_issue_enc (
        .req   (ready_p0),
        .found (issue_vld_p0),
        .idx   (issue_idx_p0)
    );

    assign full         = ~free_vld_p0;
    assign disp_fire_p0 = disp_valid & free_vld_p0;

    // Same-cycle capture of a result for the op being dispatched; lowest channel wins.
    always_comb begin
        byp_j_p0  = FALSE;
        byp_k_p0  = FALSE;
        byp_vj_p0 = '0;
        byp_vk_p0 = '0;
        for (int c = N_CDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == disp_qj)) begin
                byp_j_p0  = TRUE;
                byp_vj_p0 = cdb_value[c*DATA_W +: DATA_W];
            end
            if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == disp_qk)) begin
                byp_k_p0  = TRUE;
                byp_vk_p0 = cdb_value[c*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar e = 0; e < RS_DEPTH; e++) begin : g_ent
        logic [N_CDB-1:0]  hit_j, hit_k;
        logic [DATA_W-1:0] val_j, val_k;

        for (genvar c = 0; c < N_CDB; c++) begin : g_ch
            assign hit_j[c] = busy[e] & qj_v[e] & cdb_valid[c] &
                              (cdb_tag[c*TAG_W +: TAG_W] == qj[e]);
            assign hit_k[c] = busy[e] & qk_v[e] & cdb_valid[c] &
                              (cdb_tag[c*TAG_W +: TAG_W] == qk[e]);
        end

        always_comb begin
            val_j = '0;
            val_k = '0;
            for (int c = N_CDB - 1; c >= 0; c--) begin
                if (hit_j[c]) val_j = cdb_value[c*DATA_W +: DATA_W];
                if (hit_k[c]) val_k = cdb_value[c*DATA_W +: DATA_W];
            end
        end

        assign wake_j_p0[e] = |hit_j;
        assign wake_k_p0[e] = |hit_k;
        assign wval_j_p0[e] = val_j;
        assign wval_k_p0[e] = val_k;
    end

    always_comb begin
        count_nxt_p0 = count;
        if (disp_fire_p0 && !issue_vld_p0)
            count_nxt_p0 = count + CNT_W'(1);
        else if (!disp_fire_p0 && issue_vld_p0)
            count_nxt_p0 = count - CNT_W'(1);
    end

    // ---- stage p1: occupancy, issue bundle register and entry update ----
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            count     <= '0;
            alu_valid <= FALSE;
            alu_op    <= '0;
            alu_pc    <= '0;
            alu_vj    <= '0;
            alu_vk    <= '0;
            alu_imm   <= '0;
            alu_dest  <= '0;
        end else if (rdy) begin
            if (clr) begin
                busy      <= '0;
                count     <= '0;
                alu_valid <= FALSE;
            end else begin
                alu_valid <= issue_vld_p0;
                if (issue_vld_p0) begin
                    alu_op               <= op[issue_idx_p0];
                    alu_pc               <= pc[issue_idx_p0];
                    alu_vj               <= vj[issue_idx_p0];
                    alu_vk               <= vk[issue_idx_p0];
                    alu_imm              <= imm[issue_idx_p0];
                    alu_dest             <= dest[issue_idx_p0];
                    busy[issue_idx_p0]   <= FALSE;
                end
                // The free slot is never the issuing slot, so these never collide.
                if (disp_fire_p0)
                    busy[free_idx_p0] <= TRUE;
                count <= count_nxt_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && !clr) begin
            for (int e = 0; e < RS_DEPTH; e++) begin
                if (wake_j_p0[e]) begin
                    qj_v[e] <= FALSE;
                    vj[e]   <= wval_j_p0[e];
                end
                if (wake_k_p0[e]) begin
                    qk_v[e] <= FALSE;
                    vk[e]   <= wval_k_p0[e];
                end
            end
            if (disp_fire_p0) begin
                op[free_idx_p0]   <= disp_op;
                pc[free_idx_p0]   <= disp_pc;
                imm[free_idx_p0]  <= disp_imm;
                dest[free_idx_p0] <= disp_dest;
                qj[free_idx_p0]   <= disp_qj;
                qk[free_idx_p0]   <= disp_qk;
                qj_v[free_idx_p0] <= disp_qj_v & ~byp_j_p0;
                qk_v[free_idx_p0] <= disp_qk_v & ~byp_k_p0;
                vj[free_idx_p0]   <= (disp_qj_v && byp_j_p0) ? byp_vj_p0 : disp_vj;
                vk[free_idx_p0]   <= (disp_qk_v && byp_k_p0) ? byp_vk_p0 : disp_vk;
            end
        end
    end

endmodule

// File: tb/tb_rs_wakeup_station.sv
// Scoreboard bench for rs_wakeup_station: expected issue bundles queued at dispatch, checked at issue.
module tb_rs_wakeup_station;

    logic        clk = 1'b0;
    logic        rst, rdy, clr;
    logic        full;
    logic [4:0]  count;
    logic        disp_valid;
    logic [5:0]  disp_op;
    logic [31:0] disp_pc, disp_vj, disp_vk, disp_imm;
    logic        disp_qj_v, disp_qk_v;
    logic [3:0]  disp_qj, disp_qk, disp_dest;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_value;
    logic        alu_valid;
    logic [5:0]  alu_op;
    logic [31:0] alu_pc, alu_vj, alu_vk, alu_imm;
    logic [3:0]  alu_dest;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] pc;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] imm;
        logic [3:0]  dest;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic live_edge = 1'b0;

    rs_wakeup_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .full(full), .count(count),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_pc(disp_pc),
        .disp_qj_v(disp_qj_v), .disp_qk_v(disp_qk_v), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_imm(disp_imm), .disp_dest(disp_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .alu_valid(alu_valid), .alu_op(alu_op), .alu_pc(alu_pc), .alu_vj(alu_vj),
        .alu_vk(alu_vk), .alu_imm(alu_imm), .alu_dest(alu_dest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // A new bundle is only produced by an edge where the station was enabled and not in reset.
    always @(posedge clk) live_edge <= rdy && !rst;

    always @(negedge clk) begin
        if (live_edge && alu_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_issue", {28'h0, alu_dest}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("issue_op",   {26'h0, alu_op},   {26'h0, e.op});
                chk("issue_pc",   alu_pc,            e.pc);
                chk("issue_vj",   alu_vj,            e.vj);
                chk("issue_vk",   alu_vk,            e.vk);
                chk("issue_imm",  alu_imm,           e.imm);
                chk("issue_dest", {28'h0, alu_dest}, {28'h0, e.dest});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        disp_valid = 1'b0;
        cdb_valid  = 2'b00;
        clr        = 1'b0;
    endtask

    task automatic disp(input logic [5:0] o, input logic [31:0] p,
                        input logic jv, input logic [3:0] jt, input logic [31:0] jval,
                        input logic kv, input logic [3:0] kt, input logic [31:0] kval,
                        input logic [31:0] im, input logic [3:0] d);
        disp_valid = 1'b1;
        disp_op = o;   disp_pc = p;
        disp_qj_v = jv; disp_qj = jt; disp_vj = jval;
        disp_qk_v = kv; disp_qk = kt; disp_vk = kval;
        disp_imm = im; disp_dest = d;
    endtask

    task automatic push(input logic [5:0] o, input logic [31:0] p, input logic [31:0] j,
                        input logic [31:0] k, input logic [31:0] im, input logic [3:0] d);
        exp_t e;
        e.op = o; e.pc = p; e.vj = j; e.vk = k; e.imm = im; e.dest = d;
        sb.push_back(e);
    endtask

    task automatic cdb(input int c, input logic [3:0] t, input logic [31:0] v);
        cdb_valid[c]          = 1'b1;
        cdb_tag[c*4 +: 4]     = t;
        cdb_value[c*32 +: 32] = v;
    endtask

    // Fields of the fill pattern used for entry e.
    task automatic push_fill(input int e, input logic [31:0] j);
        push(6'(e), 32'h1000 + 32'(e * 4), j, 32'h100 + 32'(e), 32'h2000 + 32'(e), 4'(e));
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        quiet();
        disp_op = '0; disp_pc = '0; disp_qj_v = 1'b0; disp_qk_v = 1'b0;
        disp_qj = '0; disp_qk = '0; disp_vj = '0; disp_vk = '0; disp_imm = '0; disp_dest = '0;
        cdb_tag = '0; cdb_value = '0;
        repeat (3) tick();
        chk("rst_count", {27'h0, count}, 32'd0);
        chk("rst_alu_valid", {31'h0, alu_valid}, 32'd0);
        chk("rst_full", {31'h0, full}, 32'd0);
        chk("rst_alu_vj", alu_vj, 32'd0);
        chk("rst_alu_dest", {28'h0, alu_dest}, 32'd0);
        rst = 1'b0;

        // Both operands ready: one cycle to occupy, one to issue.
        disp(6'h05, 32'h100, 0, 0, 32'd3, 0, 0, 32'd4, 32'h11, 4'd2);
        push(6'h05, 32'h100, 32'd3, 32'd4, 32'h11, 4'd2);
        tick(); quiet();
        chk("t1_count_after_disp", {27'h0, count}, 32'd1);
        chk("t1_no_issue_yet", {31'h0, alu_valid}, 32'd0);
        tick();
        chk("t1_alu_valid", {31'h0, alu_valid}, 32'd1);
        chk("t1_count_after_issue", {27'h0, count}, 32'd0);
        tick();
        chk("t1_alu_valid_drop", {31'h0, alu_valid}, 32'd0);

        // Pending j operand woken by channel 1 three cycles after dispatch.
        disp(6'h0A, 32'h200, 1, 4'd7, 32'd0, 0, 0, 32'd5, 32'h22, 4'd3);
        push(6'h0A, 32'h200, 32'hDEAD, 32'd5, 32'h22, 4'd3);
        tick(); quiet();
        cdb(0, 4'd6, 32'hBAD);
        tick(); quiet();
        chk("t2_wait1", {31'h0, alu_valid}, 32'd0);
        tick();
        chk("t2_wait2", {31'h0, alu_valid}, 32'd0);
        cdb(1, 4'd7, 32'hDEAD);
        tick(); quiet();
        chk("t2_woken_not_issued", {31'h0, alu_valid}, 32'd0);
        tick();
        chk("t2_issue_two_after_bcast", {31'h0, alu_valid}, 32'd1);
        chk("t2_alu_vj", alu_vj, 32'hDEAD);
        tick();

        // Same-cycle bypass on tag 0.
        disp(6'h0C, 32'h300, 0, 0, 32'd1, 1, 4'd0, 32'd0, 32'h33, 4'd4);
        cdb(0, 4'd0, 32'd9);
        push(6'h0C, 32'h300, 32'd1, 32'd9, 32'h33, 4'd4);
        tick(); quiet();
        chk("t3_not_yet", {31'h0, alu_valid}, 32'd0);
        tick();
        chk("t3_bypass_issue", {31'h0, alu_valid}, 32'd1);
        chk("t3_bypass_vk", alu_vk, 32'd9);
        tick();

        // Fill every slot with pending ops; entries 3 and 10 wait on tag 9, the rest on tag 5.
        for (int e = 0; e < 16; e++) begin
            if (e == 15) chk("t4_not_full_at_15", {31'h0, full}, 32'd0);
            disp(6'(e), 32'h1000 + 32'(e * 4), 1, (e == 3 || e == 10) ? 4'd9 : 4'd5, 32'd0,
                 0, 0, 32'h100 + 32'(e), 32'h2000 + 32'(e), 4'(e));
            tick();
        end
        quiet();
        chk("t4_full", {31'h0, full}, 32'd1);
        chk("t4_count16", {27'h0, count}, 32'd16);
        disp(6'h3F, 32'hBEEF, 0, 0, 32'h77, 0, 0, 32'h78, 32'h0, 4'hA);
        tick(); quiet();
        chk("t4_ignored_count", {27'h0, count}, 32'd16);
        chk("t4_ignored_full", {31'h0, full}, 32'd1);
        cdb(0, 4'd9, 32'h99);
        push_fill(3, 32'h99);
        push_fill(10, 32'h99);
        tick(); quiet();
        chk("t4_woken_not_issued", {31'h0, alu_valid}, 32'd0);
        tick();
        chk("t4_first_dest", {28'h0, alu_dest}, 32'd3);
        chk("t4_count15", {27'h0, count}, 32'd15);
        tick();
        chk("t4_second_dest", {28'h0, alu_dest}, 32'd10);
        chk("t4_count14", {27'h0, count}, 32'd14);

        // Ready op into slot 3, then dispatch while it issues: new op must go to slot 10.
        disp(6'h21, 32'h3000, 0, 0, 32'h30, 0, 0, 32'h31, 32'h32, 4'hE);
        push(6'h21, 32'h3000, 32'h30, 32'h31, 32'h32, 4'hE);
        tick();
        chk("t5_count15", {27'h0, count}, 32'd15);
        disp(6'h22, 32'h3004, 1, 4'd5, 32'd0, 0, 0, 32'h40, 32'h41, 4'hF);
        tick(); quiet();
        chk("t5_count_unchanged", {27'h0, count}, 32'd15);
        chk("t5_issued_dest", {28'h0, alu_dest}, 32'hE);
        chk("t5_not_full", {31'h0, full}, 32'd0);
        cdb(1, 4'd5, 32'h55);
        for (int e = 0; e < 16; e++) begin
            if (e == 10) push(6'h22, 32'h3004, 32'h55, 32'h40, 32'h41, 4'hF);
            else if (e != 3) push_fill(e, 32'h55);
        end
        tick(); quiet();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) chk("t5_drain_timeout", sb.size(), 32'd0);
        tick();
        chk("t5_drained_count", {27'h0, count}, 32'd0);
        chk("t5_drained_valid", {31'h0, alu_valid}, 32'd0);

        // Flush with five busy entries (one about to issue), a dispatch and a CDB hit.
        for (int i = 0; i < 4; i++) begin
            disp(6'h10 + 6'(i), 32'h4000 + 32'(i * 4), 1, 4'd6, 32'd0, 0, 0, 32'(i), 32'd0, 4'(i));
            tick();
        end
        disp(6'h14, 32'h4010, 0, 0, 32'h1, 0, 0, 32'h2, 32'd0, 4'd4);
        tick(); quiet();
        chk("t6_count5", {27'h0, count}, 32'd5);
        clr = 1'b1;
        disp(6'h15, 32'h4014, 0, 0, 32'h3, 0, 0, 32'h4, 32'd0, 4'd5);
        cdb(1, 4'd6, 32'h66);
        tick(); quiet();
        chk("t6_clr_count", {27'h0, count}, 32'd0);
        chk("t6_clr_valid", {31'h0, alu_valid}, 32'd0);
        chk("t6_clr_full", {31'h0, full}, 32'd0);
        cdb(0, 4'd6, 32'h66);
        tick(); quiet();
        tick(); tick();
        chk("t6_still_empty", {27'h0, count}, 32'd0);
        chk("t6_no_issue", {31'h0, alu_valid}, 32'd0);

        // Freeze with rdy low; dispatch and CDB presented meanwhile are lost.
        disp(6'h2A, 32'h5000, 0, 0, 32'hA1, 0, 0, 32'hA2, 32'hA3, 4'd1);
        push(6'h2A, 32'h5000, 32'hA1, 32'hA2, 32'hA3, 4'd1);
        tick();
        disp(6'h2B, 32'h5004, 0, 0, 32'hB1, 0, 0, 32'hB2, 32'hB3, 4'd2);
        push(6'h2B, 32'h5004, 32'hB1, 32'hB2, 32'hB3, 4'd2);
        tick(); quiet();
        chk("t7_pre_valid", {31'h0, alu_valid}, 32'd1);
        chk("t7_pre_count", {27'h0, count}, 32'd1);
        rdy = 1'b0;
        disp(6'h2C, 32'h5008, 0, 0, 32'hC1, 0, 0, 32'hC2, 32'hC3, 4'd7);
        cdb(0, 4'd3, 32'h123);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t7_hold_valid", {31'h0, alu_valid}, 32'd1);
            chk("t7_hold_dest", {28'h0, alu_dest}, 32'd1);
            chk("t7_hold_vj", alu_vj, 32'hA1);
            chk("t7_hold_count", {27'h0, count}, 32'd1);
        end
        rdy = 1'b1;
        quiet();
        tick();
        chk("t7_resume_dest", {28'h0, alu_dest}, 32'd2);
        chk("t7_resume_count", {27'h0, count}, 32'd0);
        tick();
        chk("t7_idle_valid", {31'h0, alu_valid}, 32'd0);
        tick(); tick();
        chk("sb_drain", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
